lcd_ctrl: RTL
=============

LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- T_SETUP, 4: cycles RS/data are stable before EN rises.
- T_EN, 12: cycles EN is held high.
- T_HOLD, 4: cycles RS/data are held after EN falls.
- T_CMD, 2500: execution wait for normal commands and data.
- T_CLR, 100000: execution wait for clear/home commands.
- T_PWRUP, 750000: power-up wait before initialisation.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_clk, in, 1: clock, rising edge.
- i_rst, in, 1: reset, asynchronous, active-high.
- i_req_vld, in, 1: write request valid.
- i_req_rs, in, 1: 0 = command, 1 = data.
- i_req_data, in, 8: byte to write.
- o_req_rdy, out, 1: controller can accept a request.
- o_init_done, out, 1: power-up initialisation complete.
- o_lcd_on, out, 1: LCD power enable.
- o_lcd_rs, out, 1: LCD register select.
- o_lcd_rw, out, 1: LCD read/write; always 0 (write only).
- o_lcd_en, out, 1: LCD enable strobe.
- o_lcd_data, out, 8: LCD data bus.
REQ-003 Request source: the core's memory-mapped LCD register in the load-store unit drives i_req_*; all lcd_* outputs drive the LCD pins directly.

Function
REQ-004 FSM states: PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT. One down-counter, wide enough for T_PWRUP, times every state.
REQ-005 PWRUP lasts T_PWRUP cycles after reset release, then issues the init writes 0x38, 0x0C, 0x01, 0x06 in order with RS=0.
REQ-006 Each init write uses the same SETUP/PULSE/HOLD/WAIT sequence as a user write.
REQ-007 o_init_done rises on the cycle the FSM first enters IDLE after the fourth init write; it stays high until reset.
REQ-008 Handshake: a request is accepted on a rising edge with i_req_vld=1 and o_req_rdy=1.
REQ-009 o_req_rdy is 1 only in IDLE with o_init_done=1.
REQ-010 On acceptance, i_req_rs and i_req_data are captured into internal registers. Inputs are ignored while o_req_rdy=0.
REQ-011 SETUP: o_lcd_rs and o_lcd_data drive the captured values and o_lcd_en=0, for T_SETUP cycles.
REQ-012 PULSE: o_lcd_en=1 for exactly T_EN cycles, with RS and data unchanged.
REQ-013 HOLD: o_lcd_en=0 for T_HOLD cycles, with RS and data unchanged.
REQ-014 WAIT length: T_CLR if the captured RS=0 and data is 0x01 or 0x02, otherwise T_CMD. RS and data stay held during WAIT.
REQ-015 o_req_rdy reasserts exactly T_SETUP+T_EN+T_HOLD+Twait cycles after the accepting edge.
REQ-016 If i_req_vld stays high in IDLE, back-to-back requests are accepted at that spacing with no extra idle cycle.
REQ-017 o_lcd_on is 0 during reset and 1 from the first clock edge after reset release.
REQ-018 o_lcd_rw is constant 0.
REQ-019 All outputs are registered; no combinational path from i_req_* to any lcd_* output.
REQ-020 Counters saturate at 0. Any parameter value of 0 is treated as 1 cycle.

Reset
REQ-021 While i_rst=1, all outputs are 0 immediately and asynchronously: en, rs, rw, data, on, rdy, init_done.
REQ-022 Also while i_rst=1: FSM is in PWRUP, the counter is loaded with T_PWRUP, and the init index is 0.
REQ-023 Reset asserted mid-transfer (any state) aborts the transfer. o_lcd_en drops in the same cycle, and the full power-up and init sequence restarts after release.

Verification
Bench parameters: T_SETUP=2, T_EN=3, T_HOLD=2, T_CMD=5, T_CLR=10, T_PWRUP=20.
REQ-024 Release reset -> four EN pulses of 3 cycles each, with data 0x38/0x0C/0x01/0x06 and RS=0; o_init_done and o_req_rdy rise 73 cycles after release.
REQ-025 Accept RS=1, data=0x41 -> o_lcd_en high in cycles 3-5 after the accepting edge, data=0x41 and rs=1 throughout; o_req_rdy back after 12 cycles.
REQ-026 Accept RS=0, data=0x01 -> o_req_rdy back after 17 cycles. The same test with data=0x80 -> back after 12 cycles.
REQ-027 Accept 0x41, then change i_req_data every cycle with i_req_vld=1 while busy -> only 0x41 appears on the bus. With vld held continuously, the next accept occurs exactly 12 cycles later with the data present at that edge.
REQ-028 Assert i_rst during the 2nd cycle of a PULSE -> o_lcd_en=0 and o_req_rdy=0 in the same cycle; after release the init sequence repeats exactly as in REQ-024.

Source files
------------

// File: rtl/lcd_ctrl.sv
// HD44780-style write-only LCD controller: power-up wait, fixed init
// sequence, then timed SETUP/PULSE/HOLD/WAIT writes per accepted request.
module lcd_ctrl #(
    parameter int T_SETUP = 4,
    parameter int T_EN    = 12,
    parameter int T_HOLD  = 4,
    parameter int T_CMD   = 2500,
    parameter int T_CLR   = 100000,
    parameter int T_PWRUP = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_vld,
    input  logic       i_req_rs,
    input  logic [7:0] i_req_data,
    output logic       o_req_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic       o_lcd_en,
    output logic [7:0] o_lcd_data
);
    localparam int TS   = (T_SETUP < 1) ? 1 : T_SETUP;
    localparam int TE   = (T_EN    < 1) ? 1 : T_EN;
    localparam int TH   = (T_HOLD  < 1) ? 1 : T_HOLD;
    localparam int TC   = (T_CMD   < 1) ? 1 : T_CMD;
    localparam int TL   = (T_CLR   < 1) ? 1 : T_CLR;
    localparam int TP   = (T_PWRUP < 1) ? 1 : T_PWRUP;
    localparam int M1   = (TS > TE) ? TS : TE;
    localparam int M2   = (TH > TC) ? TH : TC;
    localparam int M3   = (TL > TP) ? TL : TP;
    localparam int M12  = (M1 > M2) ? M1 : M2;
    localparam int TMAX = (M12 > M3) ? M12 : M3;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        PWRUP, IDLE, SETUP, PULSE, HOLD, WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            rdy_q, rdy_d;
    logic            done_q, done_d;
    logic            on_q, on_d;
    logic            last;
    logic            is_clr;
    logic [CW-1:0]   wait_len;

    function automatic logic [7:0] init_byte(input logic [2:0] i);
        case (i)
            3'd0:    init_byte = 8'h38;
            3'd1:    init_byte = 8'h0C;
            3'd2:    init_byte = 8'h01;
            default: init_byte = 8'h06;
        endcase
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        idx_d    = idx_q;
        rs_d     = rs_q;
        data_d   = data_q;
        on_d     = 1'b1;
        last     = (cnt_q <= CW'(1));
        is_clr   = !rs_q && (data_q == 8'h01 || data_q == 8'h02);
        wait_len = is_clr ? CW'(TL) : CW'(TC);
        case (state_q)
            PWRUP: if (last) begin
                state_d = SETUP;
                cnt_d   = CW'(TS);
                rs_d    = 1'b0;
                data_d  = init_byte(idx_q);
                idx_d   = idx_q + 3'd1;
            end
            IDLE: if (i_req_vld && rdy_q) begin
                state_d = SETUP;
                cnt_d   = CW'(TS);
                rs_d    = i_req_rs;
                data_d  = i_req_data;
            end
            SETUP: if (last) begin
                state_d = PULSE;
                cnt_d   = CW'(TE);
            end
            PULSE: if (last) begin
                state_d = HOLD;
                cnt_d   = CW'(TH);
            end
            // Ahead of IDLE the ready cycle itself is the final wait cycle
            HOLD: if (last) begin
                if (idx_q < 3'd4) begin
                    state_d = WAIT;
                    cnt_d   = wait_len;
                end else if (wait_len == CW'(1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT;
                    cnt_d   = wait_len - CW'(1);
                end
            end
            WAIT: if (last) begin
                if (idx_q < 3'd4) begin
                    state_d = SETUP;
                    cnt_d   = CW'(TS);
                    rs_d    = 1'b0;
                    data_d  = init_byte(idx_q);
                    idx_d   = idx_q + 3'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = PWRUP;
        endcase
        en_d   = (state_d == PULSE);
        rdy_d  = (state_d == IDLE);
        done_d = done_q | rdy_d;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= PWRUP;
            cnt_q   <= CW'(TP);
            idx_q   <= 3'd0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
            done_q  <= 1'b0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            done_q  <= done_d;
            on_q    <= on_d;
        end
    end

    assign o_req_rdy   = rdy_q;
    assign o_init_done = done_q;
    assign o_lcd_on    = on_q;
    assign o_lcd_rs    = rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = en_q;
    assign o_lcd_data  = data_q;
endmodule
